secded_err_monitor: RTL and testbench
=====================================

Name: secded_err_monitor

Overview:
Sequential stage directly downstream of the Hamming(7,4) SECDED decoder. It accepts decoded nibbles and their error flags over a valid/ready handshake and classifies each word. It buffers the words in a small first-word-fall-through FIFO for the consumer. It also keeps saturating error statistics and a link-health state machine (OK / DEGRADED / FAILED) for display or software readout.

Parameters:
DEPTH, 4, FIFO depth in words; power of 2, minimum 2.
CNT_W, 8, width of each statistics counter.
CLEAN_RUN, 8, consecutive clean words needed to return from DEGRADED to OK; range 1..255.

Ports:
i_clk  input  1  single clock; everything is on its rising edge.
i_rst_n  input  1  synchronous, active-low reset.
i_clr  input  1  synchronous clear of counters and health state; does not affect FIFO contents.
i_valid  input  1  an input word is present.
o_ready  output  1  block can accept a word; equals !full, and forced 0 while i_rst_n=0.
i_data  input  4  decoded (corrected) data nibble.
i_1bit_error  input  1  decoder flagged a single-bit error in the codeword.
i_2bit_error  input  1  decoder flagged a double-bit (uncorrectable) error.
i_parity_error  input  1  decoder flagged an overall-parity mismatch.
o_valid  output  1  FIFO head is valid (FIFO not empty).
i_ready  input  1  consumer takes the head word.
o_data  output  4  FIFO head data.
o_err  output  2  FIFO head class: 00 clean, 01 corrected, 10 uncorrectable; 11 never produced.
o_cnt_total  output  CNT_W  accepted words.
o_cnt_corr  output  CNT_W  accepted words of class 01.
o_cnt_uncorr  output  CNT_W  accepted words of class 10.
o_status  output  2  health: 00 OK, 01 DEGRADED, 10 FAILED.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - FIFO emptied; o_valid=0.
  - Counters 0; o_status=00; clean-run counter 0.
  - o_data=0, o_err=00 while empty.
  - Reset mid-transfer discards all buffered words.
- Accept: a word is accepted on an edge where i_valid=1 and o_ready=1. When o_ready=0, inputs are ignored and the producer must hold them.
- Classification, evaluated on acceptance:
  - i_2bit_error=1 gives class 10, regardless of the other flags.
  - Otherwise, i_1bit_error or i_parity_error gives class 01; a lone parity error is a flip of the parity bit, which is correctable.
  - Otherwise class 00.
  - i_data is stored unchanged for every class.
- FIFO:
  - Push stores {class, data}.
  - Pop happens on an edge with o_valid=1 and i_ready=1.
  - Latency: a word accepted at edge N appears at the head with o_valid=1 after edge N, unless older words are ahead of it.
  - Head outputs are stable while o_valid=1 and i_ready=0.
  - Push and pop on the same edge: occupancy unchanged. This is legal at any occupancy below full.
  - When full, o_ready=0, so there is no push in that cycle even if a pop occurs; o_ready rises the cycle after the pop.
  - Pointers wrap modulo DEPTH.
  - The full/empty distinction uses an extra pointer bit or an occupancy counter.
- Counters:
  - On each accept, o_cnt_total increments, and o_cnt_corr or o_cnt_uncorr increments according to class.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- Health FSM, advanced only on accepted words:
  - OK: class 01 goes to DEGRADED (clean-run counter := 0); class 10 goes to FAILED; class 00 stays.
  - DEGRADED:
    - class 00: clean-run counter +1; when it reaches CLEAN_RUN, go to OK and clear the counter.
    - class 01: counter := 0, stay.
    - class 10: go to FAILED.
  - FAILED: sticky; leaves only on i_clr or reset.
  - o_status is registered and reflects the word accepted at edge N after edge N.
- i_clr:
  - At the edge, counters := 0, FSM := OK, clean-run counter := 0.
  - If an accept coincides with i_clr, the clear wins: the word is not counted and does not affect the FSM, but it is still pushed into the FIFO.
  - FIFO and handshake are unaffected.
- No combinational path from i_valid to o_ready. There is also no combinational path from i_ready to o_ready.

Test Plan:
- Reset then stream: after reset, push data 3,5,9 (all clean) with i_ready=1 -> o_data 3,5,9 in order, o_err=00 each; o_cnt_total=3; o_status=00.
- Backpressure/full (DEPTH=4): i_ready=0, push 1,2,3,4 -> o_ready=0 after the 4th; a 5th word (value 7) held on the inputs is not taken. Pulse i_ready for one cycle -> 1 is popped; o_ready=1 the next cycle and 7 is accepted; drain order is 2,3,4,7.
- Classification: words flagged {1bit}, {parity only}, {1bit+parity}, {2bit+parity} -> o_err 01, 01, 01, 10; o_cnt_corr=3, o_cnt_uncorr=1.
- Health FSM (CLEAN_RUN=8): one corrected word -> status 01; 7 clean -> still 01; corrected again -> still 01 with run reset; 8 clean -> 00; one 2bit word -> 10; 20 clean -> still 10; i_clr pulse -> 00 and counters 0.
- Saturation (CNT_W=4): 20 corrected words -> o_cnt_total=15, o_cnt_corr=15, no wrap. i_clr asserted on the same edge as a corrected word -> counters 0, status 00, and the word still emerges with o_err=01.
- Reset mid-operation: 3 words buffered, assert i_rst_n=0 for one edge -> o_valid=0, counters 0, o_status=00; the next pushed word is the first one out.

Source files
------------

// File: rtl/secded_err_monitor_if.sv
// Handshake bundle between the SECDED decoder, the error monitor and the word consumer.
// The slave side is the monitor itself; the master side drives decoded words and consumes the FIFO head.
interface secded_err_monitor_if;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_data;
  logic       i_1bit_error;
  logic       i_2bit_error;
  logic       i_parity_error;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_data;
  logic [1:0] o_err;

  modport slave (
    input  i_valid, i_data, i_1bit_error, i_2bit_error, i_parity_error, i_ready,
    output o_ready, o_valid, o_data, o_err
  );

  modport master (
    output i_valid, i_data, i_1bit_error, i_2bit_error, i_parity_error, i_ready,
    input  o_ready, o_valid, o_data, o_err
  );
endinterface

// File: rtl/secded_err_monitor.sv
// Classifies decoded Hamming(7,4) words, buffers them in a FWFT FIFO, and keeps
// saturating error statistics plus an OK/DEGRADED/FAILED link-health state.
module secded_err_monitor #(
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8,
  parameter int CLEAN_RUN = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  secded_err_monitor_if.slave  bus,
  output logic [CNT_W-1:0]     o_cnt_total,
  output logic [CNT_W-1:0]     o_cnt_corr,
  output logic [CNT_W-1:0]     o_cnt_uncorr,
  output logic [1:0]           o_status
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] RUN_LAST = 8'(CLEAN_RUN - 1);

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_FAILED   = 2'b10
  } health_e;

  // A lone parity flag means only the overall parity bit flipped, so the data is intact.
  function automatic logic [1:0] classify(input logic e1, input logic e2, input logic par);
    if (e2) begin
      return 2'b10;
    end else if (e1 || par) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [5:0]    r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [5:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_class;
  health_e       r_state;
  health_e       w_state_nx;
  logic [7:0]    r_run;
  logic [7:0]    w_run_nx;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = bus.i_valid && bus.o_ready;
  assign w_pop   = !w_empty && bus.i_ready;
  assign w_class = classify(bus.i_1bit_error, bus.i_2bit_error, bus.i_parity_error);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign bus.o_ready = !w_full && i_rst_n;
  assign bus.o_valid = !w_empty;
  assign bus.o_data  = w_empty ? 4'd0 : w_head[3:0];
  assign bus.o_err   = w_empty ? 2'b00 : w_head[5:4];
  assign o_status    = r_state;

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {w_class, bus.i_data};
    end
  end

  // FIFO pointers, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Saturating statistics; a coincident clear wins over counting the word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      o_cnt_total  <= '0;
      o_cnt_corr   <= '0;
      o_cnt_uncorr <= '0;
    end else if (w_push) begin
      o_cnt_total <= sat_inc(o_cnt_total);
      if (w_class == 2'b01) begin
        o_cnt_corr <= sat_inc(o_cnt_corr);
      end
      if (w_class == 2'b10) begin
        o_cnt_uncorr <= sat_inc(o_cnt_uncorr);
      end
    end
  end

  // Health state register and clean-run counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_OK;
      r_run   <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= w_run_nx;
    end
  end

  // Health next-state; only accepted words move it, FAILED is left only by clear/reset.
  always_comb begin
    w_state_nx = r_state;
    w_run_nx   = r_run;
    if (i_clr) begin
      w_state_nx = ST_OK;
      w_run_nx   = 8'd0;
    end else if (w_push) begin
      case (r_state)
        ST_OK: begin
          if (w_class == 2'b10) begin
            w_state_nx = ST_FAILED;
          end else if (w_class == 2'b01) begin
            w_state_nx = ST_DEGRADED;
            w_run_nx   = 8'd0;
          end else begin
            w_state_nx = ST_OK;
          end
        end
        ST_DEGRADED: begin
          if (w_class == 2'b10) begin
            w_state_nx = ST_FAILED;
          end else if (w_class == 2'b01) begin
            w_run_nx = 8'd0;
          end else if (r_run == RUN_LAST) begin
            w_state_nx = ST_OK;
            w_run_nx   = 8'd0;
          end else begin
            w_run_nx = r_run + 8'd1;
          end
        end
        ST_FAILED: begin
          w_state_nx = ST_FAILED;
        end
        default: begin
          w_state_nx = ST_FAILED;
          w_run_nx   = 8'd0;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

endmodule

// File: tb/tb_secded_err_monitor.sv
// Directed and randomized bench for secded_err_monitor, checked every cycle against
// a queue-based behavioural model of the FIFO, statistics and link health.
module tb_secded_err_monitor;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 4;
  localparam int CLEAN_RUN = 8;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic clr;
  logic [CNT_W-1:0] cnt_total, cnt_corr, cnt_uncorr;
  logic [1:0] status;

  secded_err_monitor_if bus ();

  secded_err_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W), .CLEAN_RUN(CLEAN_RUN)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clr        (clr),
    .bus          (bus),
    .o_cnt_total  (cnt_total),
    .o_cnt_corr   (cnt_corr),
    .o_cnt_uncorr (cnt_uncorr),
    .o_status     (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_q[$];
  int m_tot, m_corr, m_unc, m_st, m_run;

  function automatic int word_class(input logic e1, input logic e2, input logic par);
    if (e2) return 2;
    if (e1 || par) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int h;
    h = (m_q.size() > 0) ? m_q[0] : 0;
    chk("o_ready", 32'(bus.o_ready), 32'(rst_n && (m_q.size() < DEPTH)));
    chk("o_valid", 32'(bus.o_valid), 32'(m_q.size() > 0));
    chk("o_data", 32'(bus.o_data), 32'(h % 16));
    chk("o_err", 32'(bus.o_err), 32'(h / 16));
    chk("cnt_total", 32'(cnt_total), 32'(m_tot));
    chk("cnt_corr", 32'(cnt_corr), 32'(m_corr));
    chk("cnt_uncorr", 32'(cnt_uncorr), 32'(m_unc));
    chk("status", 32'(status), 32'(m_st));
  endtask

  task automatic tick();
    bit acc, pop;
    int cls, w;
    acc = rst_n && bus.i_valid && (m_q.size() < DEPTH);
    pop = (m_q.size() > 0) && bus.i_ready;
    cls = word_class(bus.i_1bit_error, bus.i_2bit_error, bus.i_parity_error);
    w   = cls * 16 + int'(bus.i_data);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_q.delete();
      m_tot = 0; m_corr = 0; m_unc = 0; m_st = 0; m_run = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(w);
      if (clr) begin
        m_tot = 0; m_corr = 0; m_unc = 0; m_st = 0; m_run = 0;
      end else if (acc) begin
        m_tot = (m_tot < CMAX) ? m_tot + 1 : CMAX;
        if (cls == 1) m_corr = (m_corr < CMAX) ? m_corr + 1 : CMAX;
        if (cls == 2) m_unc = (m_unc < CMAX) ? m_unc + 1 : CMAX;
        if (cls == 2) m_st = 2;
        else if (m_st == 2) m_st = 2;
        else if (cls == 1) begin m_st = 1; m_run = 0; end
        else if (m_st == 1) begin
          m_run++;
          if (m_run == CLEAN_RUN) begin m_st = 0; m_run = 0; end
        end
      end
    end
    check_all();
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic e1, input logic e2, input logic par);
    bus.i_valid = v;
    bus.i_data = d;
    bus.i_1bit_error = e1;
    bus.i_2bit_error = e2;
    bus.i_parity_error = par;
  endtask

  task automatic send_n(input int n, input logic [3:0] d, input logic e1, input logic e2, input logic par);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, d, e1, e2, par);
      tick();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int drain_exp[4];
    m_tot = 0; m_corr = 0; m_unc = 0; m_st = 0; m_run = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.i_ready = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_valid", 32'(bus.o_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // stream of clean words
    bus.i_ready = 1'b1;
    send_n(1, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("stream_head3", 32'(bus.o_data), 32'd3);
    send_n(1, 4'd5, 1'b0, 1'b0, 1'b0);
    send_n(1, 4'd9, 1'b0, 1'b0, 1'b0);
    chk("stream_total", 32'(cnt_total), 32'd3);
    for (int i = 0; i < 3; i++) tick();

    // backpressure and full
    bus.i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_n(1, 4'(i), 1'b0, 1'b0, 1'b0);
    chk("full_ready", 32'(bus.o_ready), 32'd0);
    drive(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    tick();
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk("ready_after_pop", 32'(bus.o_ready), 32'd1);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    bus.i_ready = 1'b1;
    drain_exp = '{2, 3, 4, 7};
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(bus.o_data), 32'(drain_exp[i]));
      tick();
    end
    pulse_clr();

    // classification
    send_n(1, 4'd1, 1'b1, 1'b0, 1'b0);
    chk("cls_1bit", 32'(bus.o_err), 32'd1);
    send_n(1, 4'd2, 1'b0, 1'b0, 1'b1);
    chk("cls_par", 32'(bus.o_err), 32'd1);
    send_n(1, 4'd4, 1'b1, 1'b0, 1'b1);
    send_n(1, 4'd8, 1'b0, 1'b1, 1'b1);
    chk("cls_2bit", 32'(bus.o_err), 32'd2);
    chk("cls_corr", 32'(cnt_corr), 32'd3);
    chk("cls_uncorr", 32'(cnt_uncorr), 32'd1);
    tick();
    pulse_clr();

    // health FSM
    send_n(1, 4'd6, 1'b1, 1'b0, 1'b0);
    chk("h_deg", 32'(status), 32'd1);
    send_n(7, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("h_deg7", 32'(status), 32'd1);
    send_n(1, 4'd6, 1'b1, 1'b0, 1'b0);
    send_n(7, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("h_run_reset", 32'(status), 32'd1);
    send_n(1, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("h_ok", 32'(status), 32'd0);
    send_n(1, 4'd6, 1'b0, 1'b1, 1'b0);
    chk("h_fail", 32'(status), 32'd2);
    send_n(20, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("h_sticky", 32'(status), 32'd2);
    pulse_clr();
    chk("h_clr_status", 32'(status), 32'd0);
    chk("h_clr_total", 32'(cnt_total), 32'd0);

    // saturation and clear colliding with an accept
    send_n(20, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("sat_total", 32'(cnt_total), 32'd15);
    chk("sat_corr", 32'(cnt_corr), 32'd15);
    tick();
    clr = 1'b1;
    send_n(1, 4'hC, 1'b1, 1'b0, 1'b0);
    clr = 1'b0;
    chk("clr_win_total", 32'(cnt_total), 32'd0);
    chk("clr_win_status", 32'(status), 32'd0);
    chk("clr_win_err", 32'(bus.o_err), 32'd1);
    chk("clr_win_data", 32'(bus.o_data), 32'hC);
    tick();

    // reset with words buffered
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_n(1, 4'(i + 1), 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_total", 32'(cnt_total), 32'd0);
    send_n(1, 4'hA, 1'b0, 1'b0, 1'b0);
    chk("rst_first_out", 32'(bus.o_data), 32'hA);
    bus.i_ready = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic e2;
      e2 = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) == 0), e2,
            1'($urandom_range(0, 3) == 0));
      bus.i_ready = 1'($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
